// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and defaults for the two-port register-file write arbiter.
package reg_write_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick2.sv
// Two-way round-robin pick: bit 0 of eligible is requester A, bit 1 is requester B.
module rr_pick2
  import reg_write_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    winner
);

  always_comb begin
    valid  = |eligible;
    winner = REQ_A;
    case (eligible)
      2'b01:   winner = REQ_A;
      2'b10:   winner = REQ_B;
      2'b11:   winner = other_req(last);
      default: winner = REQ_A;
    endcase
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU writeback (A) and memory load (B) onto a single register-file write port.
// Define REG_WRITE_ARBITER_HAZARD_EN to build the read-after-pending-write hazard compare.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_inaddress,
  output logic [DATA_W-1:0] rf_in,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              hazard,
  output logic [7:0]        wr_count
);

  req_id_t    last;
  logic [1:0] eligible;
  logic       pick_valid;
  req_id_t    winner;

  // A requester seeing its grant pulse this cycle has already been served.
  assign eligible = {b_req & ~b_gnt, a_req & ~a_gnt};

  rr_pick2 u_pick (
    .eligible (eligible),
    .last     (last),
    .valid    (pick_valid),
    .winner   (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      rf_write     <= 1'b0;
      rf_inaddress <= '0;
      rf_in        <= '0;
      wr_count     <= 8'd0;
      last         <= REQ_B;
    end else begin
      a_gnt    <= pick_valid && (winner == REQ_A);
      b_gnt    <= pick_valid && (winner == REQ_B);
      rf_write <= pick_valid;
      if (pick_valid) begin
        rf_inaddress <= (winner == REQ_A) ? a_addr : b_addr;
        rf_in        <= (winner == REQ_A) ? a_data : b_data;
        wr_count     <= wr_count + 8'd1;
        last         <= winner;
      end
    end
  end

`ifdef REG_WRITE_ARBITER_HAZARD_EN
  function automatic logic addr_hit(
    input logic [ADDR_W-1:0] rd,
    input logic              a_pend,
    input logic [ADDR_W-1:0] a_a,
    input logic              b_pend,
    input logic [ADDR_W-1:0] b_a,
    input logic              w_pend,
    input logic [ADDR_W-1:0] w_a
  );
    return (a_pend && (rd == a_a)) || (b_pend && (rd == b_a)) || (w_pend && (rd == w_a));
  endfunction

  // Outstanding means still waiting for a grant, or granted but not yet written.
  always_comb begin
    hazard = addr_hit(rd1_addr, a_req & ~a_gnt, a_addr, b_req & ~b_gnt, b_addr,
                      rf_write, rf_inaddress)
          || addr_hit(rd2_addr, a_req & ~a_gnt, a_addr, b_req & ~b_gnt, b_addr,
                      rf_write, rf_inaddress);
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd1_addr, rd2_addr};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter; hazard expectations follow REG_WRITE_ARBITER_HAZARD_EN.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req, a_gnt, b_gnt;
  logic [2:0] a_addr, b_addr, rf_inaddress, rd1_addr, rd2_addr;
  logic [7:0] a_data, b_data, rf_in, wr_count;
  logic       rf_write, hazard;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_gnt        (a_gnt),
    .b_req        (b_req),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_gnt        (b_gnt),
    .rf_write     (rf_write),
    .rf_inaddress (rf_inaddress),
    .rf_in        (rf_in),
    .rd1_addr     (rd1_addr),
    .rd2_addr     (rd2_addr),
    .hazard       (hazard),
    .wr_count     (wr_count)
  );

  typedef struct {
    logic       is_a;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] count;
  } exp_t;

  int      checks = 0;
  int      errors = 0;
  exp_t    exp_q[$];
  wr_req_t a_q[$];
  wr_req_t b_q[$];
  int      a_wait, b_wait, a_wait_max, b_wait_max;
  int      run_len, max_run;
  logic [7:0] rf_model [8];

`ifdef REG_WRITE_ARBITER_HAZARD_EN
  localparam logic HZ_ON = 1'b1;
`else
  localparam logic HZ_ON = 1'b0;
`endif

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit to_a, input logic [2:0] addr, input logic [7:0] data);
    wr_req_t r;
    r.addr = addr;
    r.data = data;
    if (to_a) a_q.push_back(r);
    else      b_q.push_back(r);
  endtask

  task automatic expect_write(input bit is_a, input logic [2:0] addr, input logic [7:0] data,
                              input logic [7:0] count);
    exp_t e;
    e.is_a  = is_a;
    e.addr  = addr;
    e.data  = data;
    e.count = count;
    exp_q.push_back(e);
  endtask

  // Requester models: hold a write until the grant pulse is seen, then move on.
  always @(negedge clk) begin
    if (a_req) begin
      if (a_gnt) begin
        if (a_wait > a_wait_max) a_wait_max = a_wait;
        a_wait = 0;
        a_req  = 1'b0;
      end else a_wait++;
    end
    if (!a_req && a_q.size() > 0) begin
      a_addr = a_q[0].addr;
      a_data = a_q[0].data;
      void'(a_q.pop_front());
      a_req  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (b_req) begin
      if (b_gnt) begin
        if (b_wait > b_wait_max) b_wait_max = b_wait;
        b_wait = 0;
        b_req  = 1'b0;
      end else b_wait++;
    end
    if (!b_req && b_q.size() > 0) begin
      b_addr = b_q[0].addr;
      b_data = b_q[0].data;
      void'(b_q.pop_front());
      b_req  = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rf_write) rf_model[rf_inaddress] <= rf_in;
  end

  // Monitor: every write-port cycle must match the next expected grant.
  always @(negedge clk) begin
    if (rf_write) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", 32'(rf_inaddress), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("gnt_pair", 32'({a_gnt, b_gnt}), e.is_a ? 32'd2 : 32'd1);
        check_output("rf_inaddress", 32'(rf_inaddress), 32'(e.addr));
        check_output("rf_in", 32'(rf_in), 32'(e.data));
        check_output("wr_count", 32'(wr_count), 32'(e.count));
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    max_run    = 0;
    a_wait_max = 0;
    b_wait_max = 0;
  endtask

  task automatic sync_mid();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0 || a_req || b_req)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_pending", 32'(exp_q.size() + a_q.size() + b_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_addr = '0; b_data = '0;
    rd1_addr = '0; rd2_addr = '0;
    a_wait = 0; b_wait = 0; a_wait_max = 0; b_wait_max = 0;
    run_len = 0; max_run = 0;

    do_reset();
    #1;
    check_output("rst_rf_write", 32'(rf_write), 32'd0);
    check_output("rst_gnts", 32'({a_gnt, b_gnt}), 32'd0);
    check_output("rst_rf_inaddress", 32'(rf_inaddress), 32'd0);
    check_output("rst_rf_in", 32'(rf_in), 32'd0);
    check_output("rst_wr_count", 32'(wr_count), 32'd0);
    check_output("rst_hazard", 32'(hazard), 32'd0);

    // Single write from A.
    sync_mid();
    apply_stimulus(1'b1, 3'd2, 8'd95);
    expect_write(1'b1, 3'd2, 8'd95, 8'd1);
    wait_drain(20);
    check_output("s1_r2", 32'(rf_model[2]), 32'd95);
    check_output("s1_count", 32'(wr_count), 32'd1);

    // Simultaneous A and B: A wins the first tie, B follows back-to-back.
    do_reset();
    sync_mid();
    apply_stimulus(1'b1, 3'd1, 8'd28);
    apply_stimulus(1'b0, 3'd4, 8'd6);
    expect_write(1'b1, 3'd1, 8'd28, 8'd1);
    expect_write(1'b0, 3'd4, 8'd6, 8'd2);
    wait_drain(20);
    check_output("s2_run", 32'(max_run), 32'd2);
    check_output("s2_r1", 32'(rf_model[1]), 32'd28);
    check_output("s2_r4", 32'(rf_model[4]), 32'd6);

    // Continuous requests from both: strict alternation.
    do_reset();
    sync_mid();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 3'(i), 8'(10 + i));
      apply_stimulus(1'b0, 3'(5 + i), 8'(20 + i));
    end
    for (int i = 0; i < 3; i++) begin
      expect_write(1'b1, 3'(i), 8'(10 + i), 8'(2 * i + 1));
      expect_write(1'b0, 3'(5 + i), 8'(20 + i), 8'(2 * i + 2));
    end
    wait_drain(40);
    check_output("s3_run", 32'(max_run), 32'd6);
    check_output("s3_a_wait_le2", 32'(a_wait_max <= 2), 32'd1);
    check_output("s3_b_wait_le2", 32'(b_wait_max <= 2), 32'd1);
    check_output("s3_count", 32'(wr_count), 32'd6);

    // Same destination: last granted data persists.
    do_reset();
    sync_mid();
    apply_stimulus(1'b1, 3'd4, 8'd6);
    apply_stimulus(1'b0, 3'd4, 8'd15);
    expect_write(1'b1, 3'd4, 8'd6, 8'd1);
    expect_write(1'b0, 3'd4, 8'd15, 8'd2);
    wait_drain(20);
    check_output("s4_r4", 32'(rf_model[4]), 32'd15);

    // Reset in the cycle after a grant: cancels the pulse, B stays pending.
    do_reset();
    sync_mid();
    apply_stimulus(1'b1, 3'd0, 8'd7);
    apply_stimulus(1'b0, 3'd3, 8'd9);
    expect_write(1'b1, 3'd0, 8'd7, 8'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_output("s5_rf_write", 32'(rf_write), 32'd0);
    check_output("s5_count", 32'(wr_count), 32'd0);
    check_output("s5_gnts", 32'({a_gnt, b_gnt}), 32'd0);
    check_output("s5_b_held", 32'(b_req), 32'd1);
    expect_write(1'b0, 3'd3, 8'd9, 8'd1);
    reset = 1'b0;
    wait_drain(20);
    check_output("s5_r3", 32'(rf_model[3]), 32'd9);

    // Hazard on a pending B write to r3.
    do_reset();
    rd1_addr = 3'd0;
    rd2_addr = 3'd3;
    #1;
    check_output("hz_idle", 32'(hazard), 32'd0);
    sync_mid();
    apply_stimulus(1'b0, 3'd3, 8'd44);
    expect_write(1'b0, 3'd3, 8'd44, 8'd1);
    @(negedge clk);
    #1;
    check_output("hz_pending", 32'(hazard), 32'(HZ_ON));
    @(negedge clk);
    #1;
    check_output("hz_rf_write", 32'(rf_write), 32'd1);
    check_output("hz_writing", 32'(hazard), 32'(HZ_ON));
    @(negedge clk);
    #1;
    check_output("hz_done", 32'(hazard), 32'd0);
    wait_drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the write-data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register-address width (8 registers).
REQ-003 CLK  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 RESET  in  1  SHALL be a synchronous, active-high reset.
REQ-005 A_REQ  in  1  SHALL carry the write request from requester A (ALU writeback).
REQ-006 A_ADDR  in  ADDR_W  SHALL carry requester A's destination register.
REQ-007 A_DATA  in  DATA_W  SHALL carry requester A's write data.
REQ-008 A_GNT  out  1  SHALL carry the registered one-cycle acceptance pulse to requester A.
REQ-009 B_REQ, B_ADDR, B_DATA, B_GNT SHALL be identical to the A_* ports, for requester B (memory load).
REQ-010 RF_WRITE  out  1  SHALL drive the register-file write enable.
REQ-011 RF_INADDRESS  out  ADDR_W  SHALL drive the register-file write address.
REQ-012 RF_IN  out  DATA_W  SHALL drive the register-file write data.
REQ-013 RD1_ADDR, RD2_ADDR  in  ADDR_W  SHALL carry the register-file read addresses under hazard check.
REQ-014 HAZARD  out  1  SHALL flag a read of a register with a write outstanding.
REQ-015 WR_COUNT  out  8  SHALL count accepted writes.

Function
REQ-016 A requester SHALL hold REQ, ADDR and DATA stable from assertion until it samples its GNT high; it SHALL deassert REQ, or present a new write, in the cycle after GNT.
REQ-017 A requester whose GNT is currently high SHALL be ineligible at the current edge, so no write is accepted twice.
REQ-018 At each rising edge, the arbiter SHALL pick the winner among eligible requesters with REQ=1:
- Only one eligible requester: that requester wins.
- Both eligible: the requester not granted last wins (round-robin pointer LAST).
REQ-019 LAST SHALL update only on a grant.
REQ-020 On a grant at edge k, the following SHALL be registered for cycle k..k+1:
- the winner's GNT=1;
- RF_WRITE=1;
- RF_INADDRESS and RF_IN set to the winner's ADDR and DATA.
The register file then writes at edge k+1.
REQ-021 With no grant at an edge, RF_WRITE and both GNTs SHALL be 0 in the next cycle; RF_INADDRESS and RF_IN SHALL hold their previous values.
REQ-022 Throughput SHALL be at most one write per cycle in total and at most one write every two cycles per requester.
REQ-023 A requester with continuous REQ SHALL wait at most 2 cycles for a grant (no starvation).
REQ-024 WR_COUNT SHALL increment by 1 per grant and wrap from 255 to 0.
REQ-025 Equal A_ADDR and B_ADDR requests SHALL be serialized in grant order, so the last granted data persists.

Reset
REQ-026 When RESET=1 at an edge, the following SHALL take the values listed:
- RF_WRITE=0, A_GNT=0, B_GNT=0;
- RF_INADDRESS=0, RF_IN=0;
- WR_COUNT=0;
- LAST=B, so A wins the first tie.
REQ-027 Requests present during a RESET edge SHALL NOT be accepted and SHALL remain pending; a grant pulse in flight SHALL be cancelled on the next cycle.
REQ-028 RESET SHALL take priority over every other event at the same edge.

Configuration
REQ-029 With macro REG_WRITE_ARBITER_HAZARD_EN defined, HAZARD SHALL be combinational and high when either read address (RD1_ADDR or RD2_ADDR) equals any of:
- A_ADDR with A_REQ=1 and A_GNT=0;
- B_ADDR with B_REQ=1 and B_GNT=0;
- RF_INADDRESS with RF_WRITE=1.
REQ-030 Without REG_WRITE_ARBITER_HAZARD_EN, HAZARD SHALL be tied to 0 and no compare logic SHALL be built.

Structure
REQ-031 A shared package SHALL hold:
- DATA_W and ADDR_W defaults;
- the requester-ID enum (REQ_A, REQ_B), used for LAST;
- the write-request struct (addr, data).
REQ-032 One sub-module, rr_pick2 (2-way round-robin pick from eligible vector and LAST), SHALL be instantiated; all remaining logic stays in reg_write_arbiter.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then A_REQ=1, A_ADDR=2, A_DATA=95 for 1 edge -> next cycle A_GNT=1, RF_WRITE=1, RF_INADDRESS=2, RF_IN=95; WR_COUNT=1; the register file reads 95 from r2.
- A and B request in the same cycle from reset (A: r1=28, B: r4=6) -> A granted first, B granted the next cycle; RF_WRITE high for 2 consecutive cycles.
- A and B hold REQ continuously for 6 cycles -> grants alternate A, B, A, B, A, B; neither waits more than 2 cycles.
- A and B both target r4 (A data 6, B data 15), simultaneous from reset -> r4 ends at 15.
- RESET asserted in the cycle after a grant edge -> RF_WRITE=0 next cycle; WR_COUNT=0; a held B_REQ is granted only after RESET deasserts.
- With the macro defined, B_REQ=1, B_ADDR=3, RD2_ADDR=3 -> HAZARD=1 until RF_WRITE completes, then 0; same stimulus without the macro -> HAZARD=0 throughout.
